cutie_weight_bank_reader: RTL and testbench

// - Read-side sequencer for one OCU weight memory bank: streams all weight words of one layer to the OCU.
// - Counterpart of the weight-bank write/load path; consumes the bank layout fixed by cutie_params.
// - Sits between a single-port weight SRAM bank (1-cycle read latency) and the OCU's valid/ready weight input.

---
 rtl/cutie_weight_bank_reader.sv | 182 ++++++++++++++++++
 tb/tb_cutie_weight_bank_reader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cutie_weight_bank_reader.sv
// Read-side sequencer for one OCU weight bank: walks a layer's words out of a 1-cycle SRAM
// into a 2-entry output FIFO. Optional per-beat tags (kpos/word/last) under CUTIE_WEIGHT_TAG_EN.
module cutie_weight_bank_reader #(
  parameter int N_I            = 96,
  parameter int K              = 3,
  parameter int WEIGHT_STAGGER = 2,
  parameter int NUM_LAYERS     = 8,
  parameter int DEPTH          = NUM_LAYERS * WEIGHT_STAGGER * K * K,
  parameter int ADDRW          = $clog2(DEPTH)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  input  logic [$clog2(NUM_LAYERS)-1:0]       layer_i,
  input  logic [$clog2(WEIGHT_STAGGER+1)-1:0] stagger_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                err_o,
  output logic                                mem_req_o,
  output logic [ADDRW-1:0]                    mem_addr_o,
  input  logic [N_I-1:0]                      mem_rdata_i,
  output logic [N_I-1:0]                      data_o,
  output logic                                valid_o,
  input  logic                                ready_i
`ifdef CUTIE_WEIGHT_TAG_EN
  ,
  output logic [$clog2(K*K)-1:0]              kpos_o,
  output logic [$clog2(WEIGHT_STAGGER)-1:0]   word_o,
  output logic                                last_o
`endif
);

  localparam int SW  = $clog2(WEIGHT_STAGGER + 1);
  localparam int KPW = $clog2(K * K);
  localparam int WDW = $clog2(WEIGHT_STAGGER);
  localparam int WPL = WEIGHT_STAGGER * K * K;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t           r_state;
  logic [ADDRW-1:0] r_base;
  logic [SW-1:0]    r_stagger;
  logic [KPW-1:0]   r_kpos;
  logic [WDW-1:0]   r_word;
  logic [ADDRW-1:0] r_last_addr;
  logic             r_infl;
  logic             r_done;
  logic             r_err;
  logic [1:0]       r_count;
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [N_I-1:0]   r_fifo [2];

  logic             w_push;
  logic             w_pop;
  logic             w_room;
  logic             w_req;
  logic             w_word_last;
  logic             w_last_issue;
  logic [1:0]       w_count_next;
  logic [ADDRW-1:0] w_addr;

  assign w_push       = r_infl;
  assign w_pop        = valid_o & ready_i;
  assign w_count_next = r_count + 2'(w_push) - 2'(w_pop);
  assign w_word_last  = (SW'(r_word) == r_stagger - SW'(1));
  assign w_last_issue = (r_kpos == KPW'(K * K - 1)) && w_word_last;
  assign w_addr       = r_base + ADDRW'(32'(r_kpos) * WEIGHT_STAGGER) + ADDRW'(r_word);

  // Room counts this cycle's pop so a full pipeline (issue, in flight, head) sustains 1 beat/cycle.
  assign w_room = (r_count == 2'd0)
                | ((r_count == 2'd1) & (!r_infl | w_pop))
                | ((r_count == 2'd2) & !r_infl & w_pop);
  assign w_req  = (r_state == S_RUN) && w_room;

  assign mem_req_o  = w_req;
  assign mem_addr_o = w_req ? w_addr : r_last_addr;
  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign valid_o    = (r_count != 2'd0);
  assign data_o     = r_fifo[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_stagger   <= '0;
      r_kpos      <= '0;
      r_word      <= '0;
      r_last_addr <= '0;
      r_infl      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_count     <= 2'd0;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_infl  <= w_req;
      r_count <= w_count_next;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      if (w_req) begin
        r_last_addr <= w_addr;
        if (w_word_last) begin
          r_word <= '0;
          r_kpos <= r_kpos + KPW'(1);
        end else begin
          r_word <= r_word + WDW'(1);
        end
      end
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (stagger_i > SW'(WEIGHT_STAGGER)) begin
              r_err <= 1'b1;
            end else if (stagger_i == '0) begin
              r_done <= 1'b1;
            end else begin
              r_base    <= ADDRW'(32'(layer_i) * WPL);
              r_stagger <= stagger_i;
              r_kpos    <= '0;
              r_word    <= '0;
              r_state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_req && w_last_issue) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if ((w_count_next == 2'd0) && !r_infl) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_fifo[gi] <= '0;
      end else if (w_push && (r_wr_ptr == 1'(gi))) begin
        r_fifo[gi] <= mem_rdata_i;
      end
    end
  end

`ifdef CUTIE_WEIGHT_TAG_EN
  localparam int TAGW = KPW + WDW + 1;

  logic [TAGW-1:0] r_infl_tag;
  logic [TAGW-1:0] r_tag [2];

  // Tag travels alongside its read so it lands in the same FIFO slot as the data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_infl_tag <= '0;
    end else if (w_req) begin
      r_infl_tag <= {r_kpos, r_word, w_last_issue};
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_tag
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_tag[gi] <= '0;
      end else if (w_push && (r_wr_ptr == 1'(gi))) begin
        r_tag[gi] <= r_infl_tag;
      end
    end
  end

  assign {kpos_o, word_o, last_o} = r_tag[r_rd_ptr];
`endif

endmodule

// File: tb/tb_cutie_weight_bank_reader.sv
// Directed bench for cutie_weight_bank_reader: bank model, beat/address monitor, hand-derived
// expectations for address order, latency, stalls, rejects and mid-layer reset.
module tb_cutie_weight_bank_reader;

  localparam int N_I   = 96;
  localparam int DEPTH = 144;
  localparam int ADDRW = 8;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [2:0]       layer_i;
  logic [1:0]       stagger_i;
  logic             busy_o, done_o, err_o, mem_req_o;
  logic [ADDRW-1:0] mem_addr_o;
  logic [N_I-1:0]   mem_rdata_i = '0;
  logic [N_I-1:0]   data_o;
  logic             valid_o;
  logic             ready_i;
`ifdef CUTIE_WEIGHT_TAG_EN
  logic [3:0]       kpos_o;
  logic [0:0]       word_o;
  logic             last_o;
  logic [3:0]       kpos_q [$];
  logic [0:0]       word_q [$];
  logic             last_q [$];
`endif

  logic [N_I-1:0]   bank [DEPTH];
  int               n_checks = 0;
  int               n_errors = 0;

  logic [ADDRW-1:0] addr_q [$];
  logic [N_I-1:0]   data_q [$];
  int done_cnt, err_cnt, busy_seen, stall_err, ovf_cnt;
  int issued, accepted, cyc, first_acc_cyc, last_acc_cyc, done_cyc;
  logic             prev_stall;
  logic [N_I-1:0]   prev_data;
  logic             req_s = 1'b0;
  logic [ADDRW-1:0] addr_s = '0;
  bit               ok;

  cutie_weight_bank_reader dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .layer_i     (layer_i),
    .stagger_i   (stagger_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i)
`ifdef CUTIE_WEIGHT_TAG_EN
    ,
    .kpos_o      (kpos_o),
    .word_o      (word_o),
    .last_o      (last_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Single-port bank with one cycle of read latency; request sampled mid-cycle.
  always @(posedge clk_i) begin
    if (req_s) mem_rdata_i <= bank[addr_s];
  end

  initial begin
    forever begin
      @(negedge clk_i);
      cyc++;
      req_s  = mem_req_o;
      addr_s = mem_addr_o;
      if (issued - accepted > 2) ovf_cnt++;
      if (prev_stall && (!valid_o || data_o !== prev_data)) stall_err++;
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;
      if (mem_req_o) begin
        addr_q.push_back(mem_addr_o);
        issued++;
      end
      if (valid_o && ready_i) begin
        if (accepted == 0) first_acc_cyc = cyc;
        data_q.push_back(data_o);
`ifdef CUTIE_WEIGHT_TAG_EN
        kpos_q.push_back(kpos_o);
        word_q.push_back(word_o);
        last_q.push_back(last_o);
`endif
        accepted++;
        last_acc_cyc = cyc;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (err_o) err_cnt++;
      if (busy_o) busy_seen++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    addr_q.delete();
    data_q.delete();
`ifdef CUTIE_WEIGHT_TAG_EN
    kpos_q.delete();
    word_q.delete();
    last_q.delete();
`endif
    done_cnt = 0; err_cnt = 0; busy_seen = 0; stall_err = 0; ovf_cnt = 0;
    issued = 0; accepted = 0; first_acc_cyc = 0; last_acc_cyc = 0; done_cyc = 0;
    prev_stall = 1'b0;
  endtask

  // Returns #1 after the edge that samples start_i (i.e. inside cycle 1).
  task automatic start_layer(input int layer, input int stg);
    @(posedge clk_i); #1;
    start_i   = 1'b1;
    layer_i   = 3'(layer);
    stagger_i = 2'(stg);
    @(posedge clk_i); #1;
    start_i   = 1'b0;
  endtask

  task automatic run_until_done(input bit rnd, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk_i); #1;
      if (rnd) ready_i = 1'($urandom_range(0, 1));
      if (done_cnt != 0) begin
        seen = 1'b1;
        break;
      end
    end
    ready_i = 1'b1;
  endtask

  task automatic check_layer(input string name, input int base, input int stride, input int n);
    check({name, "_nbeats"}, 128'(data_q.size()), 128'(n));
    check({name, "_naddr"}, 128'(addr_q.size()), 128'(n));
    for (int i = 0; i < n; i++) begin
      int ea;
      ea = base + i * stride;
      check({name, "_addr"}, (i < addr_q.size()) ? 128'(addr_q[i]) : {128{1'bx}}, 128'(ea));
      check({name, "_data"}, (i < data_q.size()) ? 128'(data_q[i]) : {128{1'bx}}, 128'(bank[ea]));
    end
    check({name, "_done_cnt"}, 128'(done_cnt), 128'(1));
    check({name, "_err_cnt"}, 128'(err_cnt), 128'(0));
    check({name, "_stall"}, 128'(stall_err), 128'(0));
    check({name, "_outstanding"}, 128'(ovf_cnt), 128'(0));
    $display("[tb] %s base=%0d beats=%0d done_cnt=%0d", name, base, data_q.size(), done_cnt);
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++)
      bank[a] = {32'hC0DE_0000 + 32'(a), 32'(a) * 32'h0101_0101, ~(32'(a) << 3)};
    rst_i = 1'b1; start_i = 1'b0; layer_i = '0; stagger_i = '0; ready_i = 1'b1;
    clear_mon();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_busy",  128'(busy_o),     128'(0));
    check("rst_req",   128'(mem_req_o),  128'(0));
    check("rst_valid", 128'(valid_o),    128'(0));
    check("rst_done",  128'(done_o),     128'(0));
    check("rst_err",   128'(err_o),      128'(0));
    check("rst_addr",  128'(mem_addr_o), 128'(0));
    check("rst_data",  128'(data_o),     128'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Layer 0, stagger 2, ready held: latency and back-to-back streaming
    clear_mon();
    start_layer(0, 2);
    @(negedge clk_i);
    check("t1_req_c1",  128'(mem_req_o),  128'(1));
    check("t1_addr_c1", 128'(mem_addr_o), 128'(0));
    check("t1_busy_c1", 128'(busy_o),     128'(1));
    @(negedge clk_i);
    check("t1_valid_c2", 128'(valid_o), 128'(0));
    @(negedge clk_i);
    check("t1_valid_c3", 128'(valid_o), 128'(1));
    check("t1_data_c3",  128'(data_o),  128'(bank[0]));
    run_until_done(1'b0, ok);
    check("t1_done_seen", 128'(ok), 128'(1));
    check_layer("t1", 0, 1, 18);
    check("t1_done_lat", 128'(done_cyc - last_acc_cyc), 128'(1));
    check("t1_b2b", 128'(last_acc_cyc - first_acc_cyc), 128'(17));

    // Layer 3, stagger 1: every other word of the layer
    clear_mon();
    start_layer(3, 1);
    run_until_done(1'b0, ok);
    check("t2_done_seen", 128'(ok), 128'(1));
    check_layer("t2", 54, 2, 9);

    // Layer 5, stagger 2, random ready, with a bogus start while busy
    clear_mon();
    start_layer(5, 2);
    start_i = 1'b1; layer_i = 3'd7; stagger_i = 2'd3;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    run_until_done(1'b1, ok);
    check("t3_done_seen", 128'(ok), 128'(1));
    check_layer("t3", 90, 1, 18);

    // stagger 0: immediate done, no reads
    clear_mon();
    start_layer(1, 0);
    @(negedge clk_i);
    check("t4_done_c1", 128'(done_o),    128'(1));
    check("t4_req_c1",  128'(mem_req_o), 128'(0));
    check("t4_busy_c1", 128'(busy_o),    128'(0));
    repeat (3) @(negedge clk_i);
    check("t4_naddr",    128'(addr_q.size()), 128'(0));
    check("t4_done_cnt", 128'(done_cnt),      128'(1));
    $display("[tb] t4 stagger=0 done_cnt=%0d", done_cnt);

    // stagger 3: rejected with err
    clear_mon();
    start_layer(2, 3);
    @(negedge clk_i);
    check("t5_err_c1",  128'(err_o),  128'(1));
    check("t5_busy_c1", 128'(busy_o), 128'(0));
    repeat (3) @(negedge clk_i);
    check("t5_err_cnt",  128'(err_cnt),       128'(1));
    check("t5_busy_cnt", 128'(busy_seen),     128'(0));
    check("t5_done_cnt", 128'(done_cnt),      128'(0));
    check("t5_naddr",    128'(addr_q.size()), 128'(0));
    $display("[tb] t5 stagger=3 err_cnt=%0d", err_cnt);

    // Reset at beat 7 of layer 2, then rerun the layer from its first address
    clear_mon();
    start_layer(2, 2);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_i);
      if (accepted >= 7) begin
        ok = 1'b1;
        break;
      end
    end
    check("t6_reach_beat7", 128'(ok), 128'(1));
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("t6_busy",  128'(busy_o),     128'(0));
    check("t6_req",   128'(mem_req_o),  128'(0));
    check("t6_valid", 128'(valid_o),    128'(0));
    check("t6_done",  128'(done_o),     128'(0));
    check("t6_addr",  128'(mem_addr_o), 128'(0));
    check("t6_data",  128'(data_o),     128'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (4) @(posedge clk_i);
    check("t6_no_done", 128'(done_cnt), 128'(0));
    $display("[tb] t6 reset after beat %0d, done_cnt=%0d", accepted, done_cnt);
    clear_mon();
    start_layer(2, 2);
    run_until_done(1'b0, ok);
    check("t6b_done_seen", 128'(ok), 128'(1));
    check_layer("t6b", 36, 1, 18);

`ifdef CUTIE_WEIGHT_TAG_EN
    clear_mon();
    start_layer(7, 2);
    run_until_done(1'b0, ok);
    check("t7_done_seen", 128'(ok), 128'(1));
    check_layer("t7", 126, 1, 18);
    for (int i = 0; i < 18; i++) begin
      if (i < kpos_q.size()) begin
        check("t7_kpos", 128'(kpos_q[i]), 128'(i / 2));
        check("t7_word", 128'(word_q[i]), 128'(i % 2));
        check("t7_last", 128'(last_q[i]), 128'(i == 17));
      end else begin
        check("t7_tag_missing", 128'(kpos_q.size()), 128'(18));
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
